top_stream_ram_writer: RTL
==========================

# top_stream_ram_writer

Avalon-MM write master that drains a 32-bit Avalon-ST pixel/word stream from the MIPI capture path into the on-chip RAM's s1/s2 slave port. Software arms it with a base word address and a word count; it writes consecutive words with full byte enables, honours waitrequest, and reports completion and length errors. It sits between the capture pipeline and the Nios-side on-chip RAM in the `top` Qsys system.

## Interface
- ADDR_W, 15, word-address width of the target RAM (32768 words)
- DATA_W, 32, stream and memory data width; byteenable width is DATA_W/8
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle arm pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; sampled with start
- length  in  ADDR_W+1  words to write (0..2^ADDR_W); sampled with start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err_len  out  1  sticky; eop not on the final counted word; cleared by next accepted start
- words_written  out  ADDR_W+1  writes accepted by slave in current/last job
- snk_data  in  DATA_W  stream data
- snk_valid  in  1  stream valid
- snk_eop  in  1  end-of-packet, qualified by snk_valid
- snk_ready  out  1  stream ready
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  DATA_W/8  all ones whenever avm_write is high, else 0
- avm_chipselect  out  1  equals avm_write
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_waitrequest  in  1  slave stall; tie 0 for the zero-wait on-chip RAM

## Operation
- States: IDLE, XFER, FLUSH, DONE.
- IDLE: snk_ready=0, busy=0. start=1 → latch base_addr/length, clear words_written, err_len, accept counter; go XFER (or DONE if length==0).
- XFER: one-entry holding register feeds the master port. snk_ready = ~hold_full | (avm_write & ~avm_waitrequest). Beat accepted (snk_valid & snk_ready) → load hold register, accept counter +1.
- avm_address = base + accept index of the held word, modulo 2^ADDR_W (wraps 0x7FFF→0x0000).
- Termination: accepted beat is the length-th word, or carries eop → no further beats accepted (snk_ready=0); go FLUSH. err_len set if eop arrives before the length-th word, or the length-th word lacks eop. Extra stream beats after termination are left un-accepted (upstream stalls).
- FLUSH: hold final write until slave accepts (avm_write & ~avm_waitrequest); then DONE.
- DONE: done=1 for exactly one cycle, busy=0 that cycle; next state IDLE.
- words_written increments on every cycle with avm_write & ~avm_waitrequest.
- start while not IDLE is ignored; no state change.

## Timing
- Reset values: snk_ready=0, busy=0, done=0, err_len=0, words_written=0, avm_write=0, avm_chipselect=0, avm_byteenable=0, avm_address=0, avm_writedata=0; state IDLE.
- Reset mid-job: pending write is abandoned immediately (avm_write drops asynchronously), no done pulse.
- start accepted at cycle T → busy=1 and snk_ready=1 at T+1.
- Beat accepted at cycle N → avm_write/address/data valid at N+1.
- Throughput 1 word/clk with waitrequest=0; length L completes with done at cycle (first beat)+L+1.
- While avm_waitrequest=1 with avm_write=1: avm_address, avm_writedata, avm_byteenable held stable; snk_ready=0 (hold register full and not draining).
- Simultaneous drain and accept in the same cycle are allowed (no bubble).
- length==0: done at T+1, no write issued, err_len=0.

## Test plan
- base 0x0010, length 4, stream 0xA0..0xA3 with eop on last, waitrequest=0 → writes 0x10..0x13 on consecutive cycles, byteenable 0xF, one done pulse, words_written=4, err_len=0.
- Same job, waitrequest high 3 cycles on second write → address 0x11/data 0xA1 held stable 4 cycles, snk_ready=0 during stall, all 4 words written in order.
- base 0x7FFE, length 4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- length 5, eop on 3rd beat → exactly 3 writes, err_len=1, done; 6th-beat-style trailing beats never accepted.
- length 0 → done one cycle after start, no avm_write; then start during busy of a length-8 job ignored (base unchanged).
- Assert reset_n low during 3rd write of a length-8 job → all outputs to reset values, no done; new job after reset completes normally.

Source files
------------

// File: rtl/top_stream_ram_writer_if.sv
// Stream-sink and Avalon-MM write-master signal bundle for the stream RAM writer.
// The master modport is the writer's side; the slave modport is the stream source plus RAM side.
interface top_stream_ram_writer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   snk_data;
    logic                snk_valid;
    logic                snk_eop;
    logic                snk_ready;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_waitrequest;

    modport master (
        input  snk_data, snk_valid, snk_eop, avm_waitrequest,
        output snk_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
    );

    modport slave (
        output snk_data, snk_valid, snk_eop, avm_waitrequest,
        input  snk_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
    );
endinterface

// File: rtl/top_stream_ram_writer.sv
// Drains a 32-bit stream into consecutive RAM words through a one-entry holding register,
// reporting completion, words written and a sticky length/eop disagreement flag.
module top_stream_ram_writer #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic [ADDR_W:0]      words_written,
    top_stream_ram_writer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     acc_cnt_r;
    logic [ADDR_W:0]     words_r;
    logic [DATA_W-1:0]   data_r;
    logic                hold_full_r;
    logic                err_r;
    logic                busy_r;
    logic                done_r;

    logic                start_ok_s;
    logic                drain_s;
    logic                ready_s;
    logic                accept_s;
    logic                last_s;
    logic                term_s;

    assign start_ok_s = (state_r == ST_IDLE) & start;
    assign drain_s    = hold_full_r & ~bus.avm_waitrequest;
    // The beat being offered would be the length-th word of the job.
    assign last_s     = ((acc_cnt_r + {{ADDR_W{1'b0}}, 1'b1}) == len_r);
    assign accept_s   = ready_s & bus.snk_valid;
    assign term_s     = accept_s & (last_s | bus.snk_eop);

    // Stream ready: room in the holding register, or it empties this very cycle.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == ST_XFER) begin
            ready_s = ~hold_full_r | drain_s;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Next-state decode for the job sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = (length == {(ADDR_W+1){1'b0}}) ? ST_DONE : ST_XFER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (term_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    state_nx_s = ST_XFER;
                end
            end
            ST_FLUSH: begin
                if (drain_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_XFER) | (state_nx_s == ST_FLUSH);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Job parameters, counters, error flag and the holding register feeding the master port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r      <= {ADDR_W{1'b0}};
            len_r       <= {(ADDR_W+1){1'b0}};
            acc_cnt_r   <= {(ADDR_W+1){1'b0}};
            words_r     <= {(ADDR_W+1){1'b0}};
            err_r       <= 1'b0;
            hold_full_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
        end else begin
            if (start_ok_s) begin
                base_r    <= base_addr;
                len_r     <= length;
                acc_cnt_r <= {(ADDR_W+1){1'b0}};
                words_r   <= {(ADDR_W+1){1'b0}};
                err_r     <= 1'b0;
            end else begin
                if (accept_s) begin
                    acc_cnt_r <= acc_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                end
                // Early eop, or the final counted word arriving without eop.
                if (accept_s & (bus.snk_eop ^ last_s)) begin
                    err_r <= 1'b1;
                end
                if (drain_s) begin
                    words_r <= words_r + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            if (accept_s) begin
                hold_full_r <= 1'b1;
                addr_r      <= base_r + acc_cnt_r[ADDR_W-1:0];
                data_r      <= bus.snk_data;
            end else if (drain_s) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    assign bus.snk_ready      = ready_s;
    assign bus.avm_write      = hold_full_r;
    assign bus.avm_chipselect = hold_full_r;
    assign bus.avm_byteenable = {(DATA_W/8){hold_full_r}};
    assign bus.avm_address    = addr_r;
    assign bus.avm_writedata  = data_r;

    assign busy          = busy_r;
    assign done          = done_r;
    assign err_len       = err_r;
    assign words_written = words_r;

endmodule
